conv_loop_counter: RTL and testbench

CONV_LOOP_COUNTER -- requirements
Module: conv_loop_counter

---
 rtl/conv_loop_counter_if.sv | 33 +++
 rtl/conv_loop_counter.sv | 109 ++++++++++
 tb/tb_conv_loop_counter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/conv_loop_counter_if.sv
// Control/status bundle for conv_loop_counter: run request, loop counts, stall/abort,
// and the live loop indices with their qualifiers.
interface conv_loop_counter_if #(
    parameter int unsigned INNER_MAX = 4,
    parameter int unsigned OUTER_MAX = 4
);
    localparam int unsigned IW  = (INNER_MAX > 1) ? $clog2(INNER_MAX) : 1;
    localparam int unsigned OW  = (OUTER_MAX > 1) ? $clog2(OUTER_MAX) : 1;
    localparam int unsigned ICW = $clog2(INNER_MAX + 1);
    localparam int unsigned OCW = $clog2(OUTER_MAX + 1);

    logic           start_i;
    logic [ICW-1:0] inner_num_i;
    logic [OCW-1:0] outer_num_i;
    logic           en_i;
    logic           abort_i;
    logic           busy_o;
    logic           valid_o;
    logic [IW-1:0]  inner_idx_o;
    logic [OW-1:0]  outer_idx_o;
    logic           last_o;
    logic           done_o;

    modport master (
        output start_i, inner_num_i, outer_num_i, en_i, abort_i,
        input  busy_o, valid_o, inner_idx_o, outer_idx_o, last_o, done_o
    );

    modport slave (
        input  start_i, inner_num_i, outer_num_i, en_i, abort_i,
        output busy_o, valid_o, inner_idx_o, outer_idx_o, last_o, done_o
    );
endinterface

// File: rtl/conv_loop_counter.sv
// Two-level (outer x inner) loop index generator with stall, abort and a one-cycle
// completion pulse; runtime counts are clamped to the hardware maxima at start.
module conv_loop_counter #(
    parameter int unsigned INNER_MAX = 4,
    parameter int unsigned OUTER_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    conv_loop_counter_if.slave ctrl
);
    localparam int unsigned IW  = (INNER_MAX > 1) ? $clog2(INNER_MAX) : 1;
    localparam int unsigned OW  = (OUTER_MAX > 1) ? $clog2(OUTER_MAX) : 1;
    localparam int unsigned ICW = $clog2(INNER_MAX + 1);
    localparam int unsigned OCW = $clog2(OUTER_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  inner_idx_q, inner_idx_d;
    logic [OW-1:0]  outer_idx_q, outer_idx_d;
    logic [ICW-1:0] inner_cnt_q, inner_cnt_d;
    logic [OCW-1:0] outer_cnt_q, outer_cnt_d;

    logic           inner_at_end;
    logic           outer_at_end;
    logic           last_w;
    logic [ICW-1:0] inner_clamp;
    logic [OCW-1:0] outer_clamp;

    // Counts are >= 1 whenever RUN is reached, so cnt-1 never underflows there.
    assign inner_at_end = (ICW'(inner_idx_q) == (inner_cnt_q - ICW'(1)));
    assign outer_at_end = (OCW'(outer_idx_q) == (outer_cnt_q - OCW'(1)));
    assign last_w       = (state_q == RUN) && inner_at_end && outer_at_end;

    assign inner_clamp = (ctrl.inner_num_i > ICW'(INNER_MAX)) ? ICW'(INNER_MAX) : ctrl.inner_num_i;
    assign outer_clamp = (ctrl.outer_num_i > OCW'(OUTER_MAX)) ? OCW'(OUTER_MAX) : ctrl.outer_num_i;

    always_comb begin
        state_d     = state_q;
        inner_idx_d = inner_idx_q;
        outer_idx_d = outer_idx_q;
        inner_cnt_d = inner_cnt_q;
        outer_cnt_d = outer_cnt_q;
        case (state_q)
            IDLE: begin
                if (ctrl.start_i) begin
                    inner_cnt_d = inner_clamp;
                    outer_cnt_d = outer_clamp;
                    inner_idx_d = '0;
                    outer_idx_d = '0;
                    state_d     = ((inner_clamp == '0) || (outer_clamp == '0)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (ctrl.abort_i) begin
                    state_d     = IDLE;
                    inner_idx_d = '0;
                    outer_idx_d = '0;
                end else if (ctrl.en_i) begin
                    if (last_w) begin
                        state_d     = DONE;
                        inner_idx_d = '0;
                        outer_idx_d = '0;
                    end else if (inner_at_end) begin
                        inner_idx_d = '0;
                        outer_idx_d = outer_idx_q + OW'(1);
                    end else begin
                        inner_idx_d = inner_idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                inner_idx_d = '0;
                outer_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            inner_idx_q <= '0;
            outer_idx_q <= '0;
            inner_cnt_q <= '0;
            outer_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            inner_idx_q <= inner_idx_d;
            outer_idx_q <= outer_idx_d;
            inner_cnt_q <= inner_cnt_d;
            outer_cnt_q <= outer_cnt_d;
        end
    end

    assign ctrl.busy_o      = (state_q == RUN) || (state_q == DONE);
    assign ctrl.valid_o     = (state_q == RUN);
    assign ctrl.done_o      = (state_q == DONE);
    assign ctrl.last_o      = last_w;
    assign ctrl.inner_idx_o = inner_idx_q;
    assign ctrl.outer_idx_o = outer_idx_q;
endmodule

// File: tb/tb_conv_loop_counter.sv
// Directed bench for conv_loop_counter (INNER_MAX=OUTER_MAX=4): each step checks
// {busy,valid,last,done,outer_idx,inner_idx} against a hand-computed value.
module tb_conv_loop_counter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    conv_loop_counter_if #(.INNER_MAX(4), .OUTER_MAX(4)) bus ();

    conv_loop_counter #(.INNER_MAX(4), .OUTER_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] e(input logic b, input logic v, input logic l,
                                     input logic d, input logic [1:0] o, input logic [1:0] i);
        return {b, v, l, d, o, i};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {bus.busy_o, bus.valid_o, bus.last_o, bus.done_o, bus.outer_idx_o, bus.inner_idx_o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (busy,valid,last,done,outer[2],inner[2])", tag, obs, exp);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        bus.start_i     = 1'b0;
        bus.inner_num_i = '0;
        bus.outer_num_i = '0;
        bus.en_i        = 1'b0;
        bus.abort_i     = 1'b0;

        tick();
        chk("reset_hold", e(0,0,0,0,2'd0,2'd0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", e(0,0,0,0,2'd0,2'd0));

        // 3x2 run, en tied high; counts changed after acceptance must not matter
        bus.inner_num_i = 3'd3; bus.outer_num_i = 3'd2; bus.en_i = 1'b1; bus.start_i = 1'b1;
        tick(); bus.start_i = 1'b0; bus.inner_num_i = 3'd1; bus.outer_num_i = 3'd4;
        chk("r1_00", e(1,1,0,0,2'd0,2'd0));
        tick(); chk("r1_01", e(1,1,0,0,2'd0,2'd1));
        tick(); chk("r1_02", e(1,1,0,0,2'd0,2'd2));
        tick(); chk("r1_10", e(1,1,0,0,2'd1,2'd0));
        tick(); chk("r1_11", e(1,1,0,0,2'd1,2'd1));
        tick(); chk("r1_12_last", e(1,1,1,0,2'd1,2'd2));
        tick(); chk("r1_done", e(1,0,0,1,2'd0,2'd0));
        tick(); chk("r1_idle", e(0,0,0,0,2'd0,2'd0));

        // 2x2 run with en low on alternate cycles
        bus.inner_num_i = 3'd2; bus.outer_num_i = 3'd2; bus.en_i = 1'b0; bus.start_i = 1'b1;
        tick(); bus.start_i = 1'b0;
        chk("r2_00", e(1,1,0,0,2'd0,2'd0));
        tick(); chk("r2_hold_00", e(1,1,0,0,2'd0,2'd0));
        bus.en_i = 1'b1; tick(); chk("r2_01", e(1,1,0,0,2'd0,2'd1));
        bus.en_i = 1'b0; tick(); chk("r2_hold_01", e(1,1,0,0,2'd0,2'd1));
        bus.en_i = 1'b1; tick(); chk("r2_10", e(1,1,0,0,2'd1,2'd0));
        bus.en_i = 1'b0; tick(); chk("r2_hold_10", e(1,1,0,0,2'd1,2'd0));
        bus.en_i = 1'b1; tick(); chk("r2_11_last", e(1,1,1,0,2'd1,2'd1));
        bus.en_i = 1'b0; tick(); chk("r2_hold_11", e(1,1,1,0,2'd1,2'd1));
        bus.en_i = 1'b1; tick(); chk("r2_done", e(1,0,0,1,2'd0,2'd0));
        tick(); chk("r2_idle", e(0,0,0,0,2'd0,2'd0));

        // zero inner count: straight to DONE, no valid cycle
        bus.inner_num_i = 3'd0; bus.outer_num_i = 3'd5; bus.start_i = 1'b1;
        tick(); bus.start_i = 1'b0;
        chk("r3_zero_done", e(1,0,0,1,2'd0,2'd0));
        tick(); chk("r3_idle", e(0,0,0,0,2'd0,2'd0));

        // 9 does not fit in the 3-bit count input; 7 is the largest over-range value
        bus.inner_num_i = 3'd7; bus.outer_num_i = 3'd1; bus.start_i = 1'b1;
        tick(); bus.start_i = 1'b0;
        chk("r4_00", e(1,1,0,0,2'd0,2'd0));
        tick(); chk("r4_01", e(1,1,0,0,2'd0,2'd1));
        tick(); chk("r4_02", e(1,1,0,0,2'd0,2'd2));
        tick(); chk("r4_03_last", e(1,1,1,0,2'd0,2'd3));
        tick(); chk("r4_done", e(1,0,0,1,2'd0,2'd0));
        tick(); chk("r4_idle", e(0,0,0,0,2'd0,2'd0));

        // abort at (1,1) with en high
        bus.inner_num_i = 3'd3; bus.outer_num_i = 3'd2; bus.start_i = 1'b1;
        tick(); bus.start_i = 1'b0;
        tick(); tick(); tick(); tick();
        chk("r5_at_11", e(1,1,0,0,2'd1,2'd1));
        bus.abort_i = 1'b1;
        tick(); bus.abort_i = 1'b0;
        chk("r5_aborted", e(0,0,0,0,2'd0,2'd0));
        tick(); chk("r5_no_done", e(0,0,0,0,2'd0,2'd0));

        // abort is ignored in IDLE: start with abort high is still accepted
        bus.inner_num_i = 3'd1; bus.outer_num_i = 3'd1; bus.abort_i = 1'b1; bus.start_i = 1'b1;
        tick(); bus.abort_i = 1'b0; bus.start_i = 1'b0;
        chk("r6_abort_idle", e(1,1,1,0,2'd0,2'd0));
        tick(); chk("r6_done", e(1,0,0,1,2'd0,2'd0));
        tick(); chk("r6_idle", e(0,0,0,0,2'd0,2'd0));

        // reset mid-run, released with start high
        bus.inner_num_i = 3'd3; bus.outer_num_i = 3'd2; bus.start_i = 1'b1;
        tick(); bus.start_i = 1'b0;
        tick(); chk("r7_01", e(1,1,0,0,2'd0,2'd1));
        rst_n = 1'b0;
        #1; chk("r7_in_reset", e(0,0,0,0,2'd0,2'd0));
        tick(); chk("r7_reset_hold", e(0,0,0,0,2'd0,2'd0));
        bus.inner_num_i = 3'd2; bus.outer_num_i = 3'd1; bus.start_i = 1'b1;
        rst_n = 1'b1;
        tick(); bus.start_i = 1'b0;
        chk("r7_fresh_00", e(1,1,0,0,2'd0,2'd0));
        tick(); chk("r7_01_last", e(1,1,1,0,2'd0,2'd1));
        tick(); chk("r7_done", e(1,0,0,1,2'd0,2'd0));
        tick(); chk("r7_idle", e(0,0,0,0,2'd0,2'd0));

        // start held high with 1x1: RUN(last), DONE, IDLE repeating
        bus.inner_num_i = 3'd1; bus.outer_num_i = 3'd1; bus.start_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick(); chk("r8_run_last", e(1,1,1,0,2'd0,2'd0));
            tick(); chk("r8_done", e(1,0,0,1,2'd0,2'd0));
            tick(); chk("r8_idle", e(0,0,0,0,2'd0,2'd0));
        end
        bus.start_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
